// File: rtl/instruction_fetch_unit.sv
// Purpose : fetches a 16-bit instruction as two little-endian byte reads at PCIn, then PCIn+1,
//           pulsing a PC increment to the address register file after each byte.
// Latency : Start sampled at edge 0 -> Done in cycle 5 with zero-wait memory; +1 cycle per MemAck wait.
// Backpr. : MemReq is held with a stable MemAddr until MemAck; after ACK_TIMEOUT unacknowledged
//           cycles in one request the fetch aborts to IDLE with Error set.
// Ports   : Clock/Reset (sync, active-low); Start/Busy/Done/Error handshake; MemAddr/MemReq/MemAck/
//           MemData byte memory port; PCIn/ARF_RegSel/ARF_FunSel PC read and increment; IROut word.
module instruction_fetch_unit #(
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] PCIn,
  output logic [15:0] MemAddr,
  output logic        MemReq,
  input  logic        MemAck,
  input  logic [7:0]  MemData,
  output logic [2:0]  ARF_RegSel,
  output logic [1:0]  ARF_FunSel,
  output logic [15:0] IROut,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_LO = 3'd1,
    INC_LO = 3'd2,
    REQ_HI = 3'd3,
    INC_HI = 3'd4,
    FIN    = 3'd5
  } state_t;

  // The abort fires in the REQ cycle whose miss would bring the count up to ACK_TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] ir_q, ir_d;
  logic        err_q, err_d;

  logic in_req;
  logic in_inc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = REQ_LO;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      REQ_LO: begin
        // An ack in the same cycle the timeout would fire wins.
        if (MemAck) begin
          ir_d[7:0] = MemData;
          state_d   = INC_LO;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      INC_LO: begin
        state_d = REQ_HI;
        cnt_d   = 8'd0;
      end
      REQ_HI: begin
        if (MemAck) begin
          ir_d[15:8] = MemData;
          state_d    = INC_HI;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      INC_HI: begin
        state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ir_q    <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  // Side-effecting outputs are qualified by Reset so an edge that resets the FSM
  // (e.g. while in INC_LO) never also increments the PC or issues a memory read.
  assign in_req = (state_q == REQ_LO) || (state_q == REQ_HI);
  assign in_inc = (state_q == INC_LO) || (state_q == INC_HI);

  assign MemReq     = in_req && Reset;
  assign MemAddr    = (in_req && Reset) ? PCIn : 16'h0000;
  assign ARF_RegSel = (in_inc && Reset) ? 3'b001 : 3'b000;
  assign ARF_FunSel = (in_inc && Reset) ? 2'b01 : 2'b00;
  assign Done       = (state_q == FIN) && Reset;
  assign Busy       = (state_q != IDLE);
  assign IROut      = ir_q;
  assign Error      = err_q;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 8, maximum cycles waited for MemAck in one request state before abort (legal range 1..255).
REQ-002 The block SHALL have the following ports:
- Clock  in  1  sole clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  fetch request; sampled only in IDLE.
- PCIn  in  16  current PC value, taken from the address register file read port (OutC with OutCSel=00).
- MemAddr  out  16  memory byte address.
- MemReq  out  1  memory read request.
- MemAck  in  1  memory read data valid.
- MemData  in  8  memory read byte.
- ARF_RegSel  out  3  register-enable bus to the address register file; bit0=PC, bit1=AR, bit2=SP.
- ARF_FunSel  out  2  function code to the address register file (01 = increment).
- IROut  out  16  assembled instruction word.
- Busy  out  1  high while not in IDLE.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  timeout flag.

Function
REQ-003 FSM states: IDLE, REQ_LO, INC_LO, REQ_HI, INC_HI, FIN.
REQ-004 IDLE: when Start=1, next state is REQ_LO, Error is cleared and IROut is held; otherwise stay.
REQ-005 REQ_LO/REQ_HI behaviour:
- MemReq=1 and MemAddr=PCIn combinationally.
- On the edge where MemAck=1, latch MemData into IROut[7:0] (REQ_LO) or IROut[15:8] (REQ_HI).
- Advance to INC_LO or INC_HI respectively.
REQ-006 INC_LO/INC_HI: for exactly one cycle, ARF_RegSel=3'b001 and ARF_FunSel=2'b01, so PC increments on that edge. Next state is REQ_HI or FIN.
REQ-007 Outside INC states: ARF_RegSel=3'b000 and ARF_FunSel=2'b00. No register file write occurs.
REQ-008 Outside REQ states: MemReq=0 and MemAddr=16'h0000.
REQ-009 FIN: Done=1 for exactly one cycle; next state is IDLE.
REQ-010 Byte order is little-endian: the byte at the original PC goes to IROut[7:0] and the byte at PC+1 goes to IROut[15:8].
REQ-011 Nominal latency with MemAck=1 in the first cycle of each request: Start sampled at edge 0 -> Done high in cycle 5 -> Busy low in cycle 6. Each MemAck wait cycle adds one cycle.
REQ-012 Timeout counter, 8 bits:
- Clears on entry to each REQ state and increments on each REQ cycle with MemAck=0.
- When the counter reaches ACK_TIMEOUT with MemAck still 0: Error becomes 1, state goes to IDLE, no Done pulse, and no further PC increment.
- IROut keeps its partially updated contents.
REQ-013 Error is sticky until Reset or the next accepted Start.
REQ-014 MemAck outside REQ states SHALL be ignored. MemAck=1 in the same cycle the timeout would fire counts as success.
REQ-015 Start while Busy=1 SHALL be ignored; no queuing.
REQ-016 PC wrap-around: PCIn=16'hFFFF fetches its low byte from FFFF and its high byte from 0000. The block performs no address arithmetic itself.
REQ-017 Busy=1 in every state except IDLE.

Reset
REQ-018 Reset=0 at a rising edge SHALL force:
- state IDLE and timeout counter 0;
- IROut=16'h0000;
- Error=0, Done=0, Busy=0, MemReq=0, MemAddr=0;
- ARF_RegSel=0, ARF_FunSel=0.
REQ-019 Reset asserted mid-fetch, including during an INC state, SHALL abort with no increment issued on that edge.

Verification
REQ-020 Nominal fetch:
- Stimulus: PC model=16'h0040; memory[0040]=8'h34, [0041]=8'h12; immediate MemAck; Start pulse.
- Required: IROut=16'h1234, Done in cycle 5, exactly two increment pulses, PC model=16'h0042.
REQ-021 Wait states:
- Stimulus: MemAck delayed 3 cycles on the low byte and 2 cycles on the high byte.
- Required: Done in cycle 10, MemAddr stable at 0040 or 0041 for the whole request, same IROut as REQ-020.
REQ-022 Timeout:
- Stimulus: ACK_TIMEOUT=4, MemAck never asserted.
- Required: Error=1 after 4 REQ_LO cycles, no Done, PC unchanged at 0040, Busy=0; next Start clears Error.
REQ-023 Wrap-around:
- Stimulus: PC=16'hFFFF, memory[FFFF]=8'hCD, [0000]=8'hAB.
- Required: IROut=16'hABCD, PC model=16'h0001.
REQ-024 Reset mid-fetch:
- Stimulus: Reset=0 during INC_LO.
- Required: all outputs at reset values next cycle, PC not incremented, Start ignored while Reset=0.
REQ-025 Busy Start:
- Stimulus: Start held high across a whole fetch.
- Required: a second fetch begins only from IDLE, at cycle 6, using PC=0042.
